div_unit: RTL
=============

# div_unit

Multi-cycle integer divider for the RV32M divide group (DIV, DIVU, REM, REMU), the sequential counterpart to the single-cycle multiply/logic ALU. It sits beside the ALU in the execute stage. It accepts one operation per start pulse, runs a radix-2 restoring loop of WIDTH iterations, and returns a registered quotient or remainder with a one-cycle done pulse. Select encoding and zero_flag semantics match the ALU so that the execute-stage result mux treats both units alike.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy=0
- operand_a  in  WIDTH  dividend
- operand_b  in  WIDTH  divisor
- div_sel_div / div_sel_divu / div_sel_rem / div_sel_remu  in  1 each  operation select, one-hot
- busy  out  1  iteration in progress; start is ignored while high
- done  out  1  one-cycle pulse; result is valid from this cycle
- result  out  WIDTH  registered quotient or remainder
- zero_flag  out  1  registered, equals (result == 0)

## Operation
- States: IDLE, CALC, DONE.
- A start is accepted in IDLE or DONE. Acceptance captures the operation, the operand magnitudes (absolute values for DIV/REM), and the sign fixups.
- Quotient sign = a[W-1]^b[W-1] (signed ops only). Remainder sign = a[W-1].
- Select priority if several are high: div > divu > rem > remu. With all selects low, the operation is accepted and completes with result 0 at normal latency.
- CALC, one iteration per cycle for WIDTH cycles:
  - {rem, quo} is shifted left 1.
  - A W+1-bit trial rem − divisor is computed. If it is non-negative, rem takes the trial value and quo LSB is set to 1.
  - A W-bit counter counts the iterations.
  - On the last iteration, sign fixup (two's-complement negate) and operation selection are applied and written to result and zero_flag. The state then moves to DONE.
- DONE lasts exactly one cycle with done=1. It then returns to IDLE, or re-enters CALC if start is high.
- Special cases (RISC-V defined, no trap):
  - Divide by zero: DIV/DIVU give all ones. REM/REMU give operand_a.
  - Signed overflow (a = −2^(W−1), b = −1): DIV gives −2^(W−1). REM gives 0.
- result and zero_flag hold their value until the next accepted operation completes. They do not change during CALC.
- A start while busy=1 is dropped. No queuing.

## Timing
- Reset (async assert): state=IDLE, busy=0, done=0, result=0, zero_flag=1, counter=0.
- Reset deassertion is synchronized externally. The first start may be accepted on the first edge after rst_n rises.
- Reset asserted mid-CALC aborts the operation immediately. No done pulse is produced.
- Cycle numbering: the cycle in which an accepted start is sampled is cycle 0.
  - busy=1 in cycles 1..WIDTH.
  - done=1 in cycle WIDTH+1, so latency is 33 cycles for WIDTH=32.
- Back-to-back: a start in the DONE cycle is accepted. Its done arrives WIDTH+1 cycles later. Throughput is one operation per WIDTH+1 cycles.
- Operands and selects may change freely after cycle 0.
- busy is low in IDLE and DONE. done is never high in two consecutive cycles unless a fast-path operation is accepted in a DONE cycle.

## Configuration
- DIV_FAST_SPECIAL_EN defined:
  - Divide-by-zero and signed-overflow cases are detected at acceptance.
  - result is written at the cycle-0 edge, the unit goes directly to DONE, and done=1 in cycle 1. busy never asserts.
- DIV_FAST_SPECIAL_EN undefined:
  - No detection logic exists.
  - Special cases run the full WIDTH iterations. The restoring algorithm with sign fixup must yield the same architecturally defined values: the bench checks this.
  - Latency is constant at WIDTH+1.

## Test plan
- DIVU 100/7 → done in cycle 33, result=14, zero_flag=0. REMU 100/7 → result=2.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIV 7/−2 → 0xFFFFFFFD. REM 7/−2 → 1.
- DIV 5/0 → 0xFFFFFFFF. REMU 5/0 → 5. With DIV_FAST_SPECIAL_EN, done in cycle 1; without it, done in cycle 33.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same operands → 0 with zero_flag=1.
- DIVU 1000/10 started; a second start with 9/3 raised at cycle 5 is ignored. Exactly one done pulse, at cycle 33, with result=100. A start in that DONE cycle with 9/3 → done 33 cycles later with result=3.
- rst_n pulled low in cycle 10 of DIVU 50/5 → busy=0, done=0, result=0 immediately, and no done pulse follows. A new DIVU 50/5 → result=10.

Source files
------------

// File: rtl/div_unit_if.sv
// div_unit_if -- request/response bundle for the sequential divider.
//
// Signals:
//   start                  request pulse, honoured only while busy is low
//   operand_a / operand_b  dividend / divisor, WIDTH bits
//   div_sel_div/divu/rem/remu  one-hot operation select (div has priority)
//   busy                   iteration loop running
//   done                   one-cycle completion pulse
//   result                 registered quotient or remainder
//   zero_flag              registered (result == 0)
//
// Modports: master drives requests (execute stage / testbench),
//           slave is the divider itself.
interface div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             div_sel_div;
   logic             div_sel_divu;
   logic             div_sel_rem;
   logic             div_sel_remu;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             zero_flag;

   modport master (
      output start, operand_a, operand_b,
      output div_sel_div, div_sel_divu, div_sel_rem, div_sel_remu,
      input  busy, done, result, zero_flag
   );

   modport slave (
      input  start, operand_a, operand_b,
      input  div_sel_div, div_sel_divu, div_sel_rem, div_sel_remu,
      output busy, done, result, zero_flag
   );
endinterface

// File: rtl/div_unit.sv
// div_unit -- multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    div_unit_if.slave (start, operands, selects in;
//          busy, done, result, zero_flag out)
//
// One operation per accepted start; WIDTH iterations in CALC, then a
// single DONE cycle with done=1. result/zero_flag only change when an
// accepted operation completes.
//
// Optional build macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed
// overflow are resolved at acceptance and skip the iteration loop.
module div_unit #(
   parameter int WIDTH = 32
) (
   input logic       clk,
   input logic       rst_n,
   div_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   typedef enum logic [2:0] {OP_NONE, OP_DIV, OP_DIVU, OP_REM, OP_REMU} op_t;

   state_t           state_reg, state_next;
   op_t              op_reg, op_sel;
   logic [WIDTH-1:0] rem_reg, quo_reg, divisor_reg, cnt_reg;
   logic             neg_q_reg, neg_r_reg;
   logic [WIDTH-1:0] result_reg;
   logic             zero_reg;

   logic             accept, signed_op, a_neg, b_neg, b_zero, last;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   shift_val, trial;
   logic [WIDTH-1:0] quo_shift, rem_new, q_fix, r_fix, final_res;
   logic             fast_hit;
   logic [WIDTH-1:0] fast_result;
   logic             busy_c, done_c;

   // ---------------- acceptance / operand conditioning ----------------
   always_comb begin
      op_sel = OP_NONE;
      if (bus.div_sel_div)       op_sel = OP_DIV;
      else if (bus.div_sel_divu) op_sel = OP_DIVU;
      else if (bus.div_sel_rem)  op_sel = OP_REM;
      else if (bus.div_sel_remu) op_sel = OP_REMU;
   end

   assign accept    = bus.start && (state_reg != CALC);
   assign signed_op = (op_sel == OP_DIV) || (op_sel == OP_REM);
   assign a_neg     = signed_op && bus.operand_a[WIDTH-1];
   assign b_neg     = signed_op && bus.operand_b[WIDTH-1];
   assign b_zero    = (bus.operand_b == '0);
   // -2^(W-1) negates to itself, which is also its correct unsigned magnitude.
   assign a_mag     = a_neg ? -bus.operand_a : bus.operand_a;
   assign b_mag     = b_neg ? -bus.operand_b : bus.operand_b;

`ifdef DIV_FAST_SPECIAL_EN
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   logic ovf;
   assign ovf = signed_op && (bus.operand_a == MIN_NEG) && (bus.operand_b == '1);
   assign fast_hit = (op_sel != OP_NONE) && (b_zero || ovf);
   always_comb begin
      fast_result = '0;
      case (op_sel)
         OP_DIV, OP_DIVU: fast_result = b_zero ? '1 : MIN_NEG;
         OP_REM, OP_REMU: fast_result = b_zero ? bus.operand_a : '0;
         default:         fast_result = '0;
      endcase
   end
`else
   assign fast_hit    = 1'b0;
   assign fast_result = '0;
`endif

   // ---------------- one restoring iteration ----------------
   // rem < divisor always holds, so the shifted value fits in W+1 bits and
   // bit W of the W+1-bit difference is a valid borrow/sign indicator.
   assign shift_val = {rem_reg, quo_reg[WIDTH-1]};
   assign trial     = shift_val - {1'b0, divisor_reg};
   assign quo_shift = {quo_reg[WIDTH-2:0], ~trial[WIDTH]};
   assign rem_new   = trial[WIDTH] ? shift_val[WIDTH-1:0] : trial[WIDTH-1:0];
   assign last      = (cnt_reg == WIDTH'(WIDTH - 1));

   assign q_fix = neg_q_reg ? -quo_shift : quo_shift;
   assign r_fix = neg_r_reg ? -rem_new : rem_new;

   always_comb begin
      final_res = '0;
      case (op_reg)
         OP_DIV, OP_DIVU: final_res = q_fix;
         OP_REM, OP_REMU: final_res = r_fix;
         default:         final_res = '0;
      endcase
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      busy_c     = 1'b0;
      done_c     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.start) state_next = fast_hit ? DONE : CALC;
         end
         CALC: begin
            busy_c = 1'b1;
            if (last) state_next = DONE;
         end
         DONE: begin
            done_c     = 1'b1;
            state_next = IDLE;
            if (bus.start) state_next = fast_hit ? DONE : CALC;
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_reg      <= OP_NONE;
         rem_reg     <= '0;
         quo_reg     <= '0;
         divisor_reg <= '0;
         cnt_reg     <= '0;
         neg_q_reg   <= 1'b0;
         neg_r_reg   <= 1'b0;
         result_reg  <= '0;
         zero_reg    <= 1'b1;
      end else if (accept) begin
         op_reg      <= op_sel;
         rem_reg     <= '0;
         quo_reg     <= a_mag;
         divisor_reg <= b_mag;
         cnt_reg     <= '0;
         // A zero divisor yields all-ones quotient regardless of the
         // dividend sign, so the quotient negate is suppressed there.
         neg_q_reg   <= (a_neg ^ b_neg) && !b_zero;
         neg_r_reg   <= a_neg;
         if (fast_hit) begin
            result_reg <= fast_result;
            zero_reg   <= (fast_result == '0);
         end
      end else if (state_reg == CALC) begin
         rem_reg <= rem_new;
         quo_reg <= quo_shift;
         cnt_reg <= cnt_reg + 1'b1;
         if (last) begin
            result_reg <= final_res;
            zero_reg   <= (final_res == '0);
         end
      end
   end

   assign bus.busy      = busy_c;
   assign bus.done      = done_c;
   assign bus.result    = result_reg;
   assign bus.zero_flag = zero_reg;

endmodule
